muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the multicycle MIPS core, implementing MULT, MULTU, DIV, DIVU and the HI/LO register pair.
- The main control FSM pulses `start` with decoded `op` and the two register operands.
- It then holds in a wait state while `busy` is high, and resumes on `done`.
- MFHI/MFLO read `hi`/`lo` directly; MTHI/MTLO write them through `hi_we`/`lo_we`.

---
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO register pair.
// Handles MULT/MULTU through shift-add and DIV/DIVU through restoring division.
// Both use one 2*WIDTH accumulator, and each op takes WIDTH iterations.
// Signed ops run on magnitudes. The sign fix-up happens in a single FIX cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   // Latched per-operation control: the opcode and the sign corrections for FIX
   typedef struct packed {
      logic [1:0] op;
      logic       neg_q;   // negate product / quotient
      logic       neg_r;   // negate remainder (dividend was negative)
   } ctl_t;

   state_t             state_q, state_d;
   ctl_t               ctl;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, acc_nx;
   logic [WIDTH-1:0]   opnd;          // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic               ready, take, dz, last;
   logic [WIDTH:0]     msum, rs;
   logic [WIDTH-1:0]   rsub;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   assign ready = (state_q == IDLE) || (state_q == DONE);
   assign take  = start && ready;
   assign dz    = take && op[1] && (b == '0);
   assign last  = (cnt == CW'(WIDTH - 1));
   assign busy  = (state_q == CALC) || (state_q == FIX);
   assign done  = (state_q == DONE);

   // Operand magnitudes. Only signed ops (op[0]==0) take the absolute value.
   always_comb begin
      a_abs = (!op[0] && a[WIDTH-1]) ? -a : a;
      b_abs = (!op[0] && b[WIDTH-1]) ? -b : b;
   end

   // One iteration step for either shift-add multiply or restoring divide
   always_comb begin
      msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      rs     = acc[2*WIDTH-1:WIDTH-1];            // remainder after the left shift
      rsub   = rs[WIDTH-1:0] - opnd;              // fits: the result is below the divisor
      acc_nx = acc;
      if (!ctl.op[1]) begin
         acc_nx = acc[0] ? {msum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
      end else if (rs >= {1'b0, opnd}) begin
         acc_nx = {rsub, acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_nx = {acc[2*WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction of the finished magnitude result
   always_comb begin
      prod = ctl.neg_q ? -acc : acc;
      if (!ctl.op[1]) begin
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end else begin
         fix_hi = ctl.neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
         fix_lo = ctl.neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic. A divide by zero skips straight to DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (take) state_d = dz ? DONE : CALC;
         CALC: if (last) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: state_d = take ? (dz ? DONE : CALC) : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath. Covers operand capture, iteration, and HI/LO updates.
   // A start wins over MTHI/MTLO in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl  <= '0;
         cnt  <= '0;
         acc  <= '0;
         opnd <= '0;
         hi   <= '0;
         lo   <= '0;
      end else begin
         if (take) begin
            ctl.op    <= op;
            ctl.neg_q <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            ctl.neg_r <= !op[0] && a[WIDTH-1];
            opnd      <= op[1] ? b_abs : a_abs;
            acc       <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
            cnt       <= '0;
         end else if (state_q == CALC) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
         end

         if (dz) begin
            hi <= a;
            lo <= '1;
         end else if (state_q == FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
         end else if (ready && !start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random bench for muldiv_unit.
// The reference model uses plain 64-bit signed/unsigned arithmetic.
module tb_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [1:0]    op = 2'd0;
   logic [W-1:0]  a = '0, b = '0, wdata = '0;
   logic          busy, done;
   logic [W-1:0]  hi, lo;
   int            ncmp = 0, nerr = 0;
   logic [W-1:0]  hi_m = '0, lo_m = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural result {hi,lo} of one MIPS mult/div instruction
   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] ux, uy, uq, ur;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      if (o == 2'd0) return sx * sy;
      if (o == 2'd1) return ux * uy;
      if (y == 0) return {x, 32'hFFFF_FFFF};
      if (o == 2'd2) begin
         q = sx / sy;
         r = sx % sy;
         return {r[31:0], q[31:0]};
      end
      uq = ux / uy;
      ur = ux % uy;
      return {ur[31:0], uq[31:0]};
   endfunction

   // Launch one op from the current negedge, then run it to DONE and check the result.
   // The optional glitch start during CALC must be ignored.
   // So must the MTHI/MTLO pulses while busy, and a write issued together with start.
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit glitch, input bit we_start);
      logic [63:0] e;
      int cyc, bc;
      bit dz;
      e  = ref_op(o, x, y);
      dz = o[1] && (y == 0);
      start = 1'b1; op = o; a = x; b = y;
      if (we_start) begin hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom; end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom;
      cyc = 1; bc = 0;
      while (!done && cyc < 100) begin
         if (busy) bc++;
         if (cyc == 10) begin
            chk("hold_hi", hi, hi_m);
            chk("hold_lo", lo, lo_m);
         end
         @(negedge clk);
         cyc++;
         start = glitch && (cyc == 5);
         lo_we = (cyc == 7);
         hi_we = (cyc == 8);
         wdata = $urandom;
      end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      chk("done", done, 1);
      chk("latency", cyc, dz ? 1 : 34);
      chk("busy_cycles", bc, dz ? 0 : 33);
      chk("hi", hi, e[63:32]);
      chk("lo", lo, e[31:0]);
      hi_m = e[63:32];
      lo_m = e[31:0];
   endtask

   initial begin
      logic [W-1:0] x, y;
      logic [1:0]   o;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      @(negedge clk);
      chk("done_drop", done, 0);
      do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1, 0);
      @(negedge clk);
      do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
      @(negedge clk);
      do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      @(negedge clk);
      do_op(2'd3, 32'd100, 32'd0, 0, 0);
      @(negedge clk);
      chk("dz_busy_after", busy, 0);

      // MTHI in IDLE, then MTHI+MTLO together
      hi_we = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0;
      hi_m = 32'h1234;
      chk("mthi_hi", hi, hi_m);
      chk("mthi_lo", lo, lo_m);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      hi_m = 32'hCAFE_F00D; lo_m = 32'hCAFE_F00D;
      chk("mtboth_hi", hi, hi_m);
      chk("mtboth_lo", lo, lo_m);

      // a write together with start is dropped, and the op runs normally
      do_op(2'd1, 32'd5, 32'd9, 0, 1);

      // back-to-back ops, including a divide by zero started from DONE
      do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);
      do_op(2'd3, 32'hFFFF_FFFF, 32'd10, 0, 0);
      do_op(2'd2, 32'hDEAD_BEEF, 32'd0, 0, 0);
      do_op(2'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 0, 0);
      @(negedge clk);

      // random ops, with some zero divisors and extreme operands mixed in
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom);
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 5))
            0: y = '0;
            1: x = 32'h8000_0000;
            2: y = 32'hFFFF_FFFF;
            3: y = 32'($urandom_range(1, 15));
            default: ;
         endcase
         do_op(o, x, y, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);

      // asynchronous reset in cycle 10 of CALC
      start = 1'b1; op = 2'd1; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
      @(posedge clk);
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_hi", hi, 0);
      chk("mid_rst_lo", lo, 0);
      hi_m = '0; lo_m = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      do_op(2'd1, 32'd6, 32'd7, 0, 0);
      chk("post_rst_lo42", lo, 42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
